alu_issue_unit: RTL and testbench

- Requester side of the 32-bit ALU datapath interface.
- Accepts operation requests on a valid/ready port and buffers them in a small FIFO.
- Drives the ALU's src1/src2/ALU_control/bonus_control for each request, captures result, zero, cout and overflow after a settle window, and returns them on a valid/ready response port.
- Sits between the ALU and any sequencing logic or testbench master.

---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Request/response channel between a sequencing master and the ALU issue unit.
interface alu_issue_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [2:0]       req_cmp;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_cout;
  logic             rsp_overflow;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_cmp, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_cmp, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_tag
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Queues ALU requests, drives the ALU for a settle window, then returns the
// captured result and flags on a valid/ready response port.
module alu_issue_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus,
  output logic        alu_rst_n,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  alu_bonus,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        busy,
  output logic [15:0] done_count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);
  localparam logic [2:0] OpIllegal = 3'd7;

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e           state_q;
  logic [2:0]       op_mem  [DEPTH];
  logic [2:0]       cmp_mem [DEPTH];
  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [SetW-1:0]  settle_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q, rsp_zero_q, rsp_cout_q, rsp_overflow_q, rsp_err_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [15:0]      done_count_q;

  logic             push, pop, rsp_fire;
  logic [2:0]       head_op;
  logic [3:0]       head_ctrl;

  assign bus.req_ready    = (count_q < CntW'(DEPTH)) && rst_n;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_cout     = rsp_cout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign done_count       = done_count_q;
  assign busy             = (state_q != StIdle) || (count_q != '0);

  assign push     = bus.req_valid && bus.req_ready;
  assign rsp_fire = (state_q == StResp) && rsp_valid_q && bus.rsp_ready;
  // Pops use the registered count, so a same-edge push to an empty FIFO waits.
  assign pop      = (count_q != '0) && ((state_q == StIdle) || rsp_fire);
  assign head_op  = op_mem[rd_ptr_q];

  always_comb begin
    head_ctrl = 4'b0000;
    case (head_op)
      3'd0:    head_ctrl = 4'b0000;
      3'd1:    head_ctrl = 4'b0001;
      3'd2:    head_ctrl = 4'b0010;
      3'd3:    head_ctrl = 4'b0110;
      3'd4:    head_ctrl = 4'b1100;
      3'd5:    head_ctrl = 4'b1101;
      3'd6:    head_ctrl = 4'b0111;
      default: head_ctrl = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      settle_q       <= '0;
      tag_q          <= '0;
      alu_rst_n      <= 1'b0;
      alu_src1       <= '0;
      alu_src2       <= '0;
      alu_ctrl       <= '0;
      alu_bonus      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_cout_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_tag_q      <= '0;
      done_count_q   <= '0;
    end else begin
      alu_rst_n <= 1'b1;
      if (push) begin
        op_mem[wr_ptr_q]  <= bus.req_op;
        cmp_mem[wr_ptr_q] <= bus.req_cmp;
        a_mem[wr_ptr_q]   <= bus.req_a;
        b_mem[wr_ptr_q]   <= bus.req_b;
        tag_mem[wr_ptr_q] <= bus.req_tag;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (rsp_fire) done_count_q <= done_count_q + 16'd1;

      if (pop) begin
        if (head_op == OpIllegal) begin
          // Illegal ops never reach the ALU; the response is synthesised here.
          rsp_result_q   <= '0;
          rsp_zero_q     <= 1'b0;
          rsp_cout_q     <= 1'b0;
          rsp_overflow_q <= 1'b0;
          rsp_err_q      <= 1'b1;
          rsp_tag_q      <= tag_mem[rd_ptr_q];
          rsp_valid_q    <= 1'b1;
          state_q        <= StResp;
        end else begin
          alu_src1    <= a_mem[rd_ptr_q];
          alu_src2    <= b_mem[rd_ptr_q];
          alu_ctrl    <= head_ctrl;
          alu_bonus   <= cmp_mem[rd_ptr_q];
          tag_q       <= tag_mem[rd_ptr_q];
          settle_q    <= '0;
          rsp_valid_q <= 1'b0;
          state_q     <= StDrive;
        end
      end else begin
        case (state_q)
          StDrive: begin
            if (settle_q == SettleLast) begin
              rsp_result_q   <= alu_result;
              rsp_zero_q     <= alu_zero;
              rsp_cout_q     <= alu_cout;
              rsp_overflow_q <= alu_overflow;
              rsp_err_q      <= 1'b0;
              rsp_tag_q      <= tag_q;
              rsp_valid_q    <= 1'b1;
              state_q        <= StResp;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          StResp: begin
            if (rsp_fire) begin
              rsp_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: vector table on a SETTLE=1 instance plus
// hand-written stall, fill, illegal-op, reset and SETTLE=3/wrap sequences.
module tb_alu_issue_unit;
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
  } alu_out_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  cmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NVEC = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.TAG_W(4)) bus1 ();
  alu_issue_if #(.TAG_W(4)) bus3 ();

  logic        a1_rst_n, a3_rst_n, busy1, busy3;
  logic [31:0] a1_src1, a1_src2, a3_src1, a3_src2;
  logic [3:0]  a1_ctrl, a3_ctrl;
  logic [2:0]  a1_bonus, a3_bonus;
  logic [15:0] done1, done3;
  alu_out_t    m1, m3;

  function automatic alu_out_t alu_model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    alu_out_t o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (c)
      4'b0000: o.result = a & b;
      4'b0001: o.result = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        o.result = s[31:0];
        o.cout = s[32];
        o.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.result = s[31:0];
        o.cout = s[32];
        o.ovf = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b1100: o.result = ~(a | b);
      4'b1101: o.result = ~(a & b);
      4'b0111: o.result = {31'd0, $signed(a) < $signed(b)};
      default: o.result = '0;
    endcase
    o.zero = (o.result == 32'd0);
    return o;
  endfunction

  always_comb m1 = alu_model(a1_ctrl, a1_src1, a1_src2);
  always_comb m3 = alu_model(a3_ctrl, a3_src1, a3_src2);

  alu_issue_unit #(.DEPTH(4), .TAG_W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .alu_rst_n(a1_rst_n), .alu_src1(a1_src1), .alu_src2(a1_src2), .alu_ctrl(a1_ctrl),
    .alu_bonus(a1_bonus), .alu_result(m1.result), .alu_zero(m1.zero), .alu_cout(m1.cout),
    .alu_overflow(m1.ovf), .busy(busy1), .done_count(done1)
  );

  alu_issue_unit #(.DEPTH(4), .TAG_W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .alu_rst_n(a3_rst_n), .alu_src1(a3_src1), .alu_src2(a3_src2), .alu_ctrl(a3_ctrl),
    .alu_bonus(a3_bonus), .alu_result(m3.result), .alu_zero(m3.zero), .alu_cout(m3.cout),
    .alu_overflow(m3.ovf), .busy(busy3), .done_count(done3)
  );

  int checks = 0;
  int failures = 0;
  vec_t vecs [NVEC];
  int lat, got, cyc, held, stale, exp_done;
  logic acc, hs;
  logic [31:0] exp_res [3];
  logic        exp_err [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [2:0] op, input logic [2:0] cmp, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    chk($sformatf("send_ready_tag%0d", tag), bus1.req_ready, 1);
    bus1.req_valid = 1'b1;
    bus1.req_op = op;
    bus1.req_cmp = cmp;
    bus1.req_a = a;
    bus1.req_b = b;
    bus1.req_tag = tag;
    tick();
    bus1.req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.req_valid = 0; bus1.req_op = 0; bus1.req_cmp = 0; bus1.req_a = 0; bus1.req_b = 0;
    bus1.req_tag = 0; bus1.rsp_ready = 0;
    bus3.req_valid = 0; bus3.req_op = 0; bus3.req_cmp = 0; bus3.req_a = 0; bus3.req_b = 0;
    bus3.req_tag = 0; bus3.rsp_ready = 0;

    //         op    cmp   a             b             tag   ctrl     result        z  c  o  e  lat
    vecs[0]  = '{3'd2, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 4'b0010, 32'h8000_0000, 0, 0, 1, 0, 2};
    vecs[1]  = '{3'd0, 3'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd1, 4'b0000, 32'h00F0_00F0, 0, 0, 0, 0, 2};
    vecs[2]  = '{3'd1, 3'd2, 32'h0000_FFFF, 32'hFFFF_0000, 4'd2, 4'b0001, 32'hFFFF_FFFF, 0, 0, 0, 0, 2};
    vecs[3]  = '{3'd3, 3'd3, 32'h0000_0005, 32'h0000_0005, 4'd4, 4'b0110, 32'h0000_0000, 1, 1, 0, 0, 2};
    vecs[4]  = '{3'd4, 3'd4, 32'h0000_0000, 32'h0000_0000, 4'd5, 4'b1100, 32'hFFFF_FFFF, 0, 0, 0, 0, 2};
    vecs[5]  = '{3'd5, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 4'b1101, 32'h0000_0000, 1, 0, 0, 0, 2};
    vecs[6]  = '{3'd6, 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, 4'b0111, 32'h0000_0001, 0, 0, 0, 0, 2};
    vecs[7]  = '{3'd2, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 4'd8, 4'b0010, 32'h0000_0000, 1, 1, 0, 0, 2};
    vecs[8]  = '{3'd7, 3'd1, 32'hDEAD_BEEF, 32'h0000_1234, 4'd9, 4'b0010, 32'h0000_0000, 0, 0, 0, 1, 1};
    vecs[9]  = '{3'd3, 3'd0, 32'h0000_0000, 32'h0000_0001, 4'd10, 4'b0110, 32'hFFFF_FFFF, 0, 0, 0, 0, 2};
    vecs[10] = '{3'd3, 3'd2, 32'h8000_0000, 32'h0000_0001, 4'd11, 4'b0110, 32'h7FFF_FFFF, 0, 1, 1, 0, 2};

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_req_ready", bus1.req_ready, 0);
    chk("rst_alu_rst_n", a1_rst_n, 0);
    chk("rst_done", done1, 0);
    chk("rst_alu_ctrl", a1_ctrl, 0);
    chk("rst_alu_src1", a1_src1, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", bus1.req_ready, 1);
    tick();
    chk("rel_alu_rst_n", a1_rst_n, 1);

    // Vector table, one request at a time with rsp_ready high.
    exp_done = 0;
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      send1(vecs[i].op, vecs[i].cmp, vecs[i].a, vecs[i].b, vecs[i].tag);
      lat = 0;
      do begin tick(); lat++; end while (!bus1.rsp_valid && lat < 20);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), bus1.rsp_result, vecs[i].result);
      chk($sformatf("v%0d_zero", i), bus1.rsp_zero, vecs[i].zero);
      chk($sformatf("v%0d_cout", i), bus1.rsp_cout, vecs[i].cout);
      chk($sformatf("v%0d_ovf", i), bus1.rsp_overflow, vecs[i].ovf);
      chk($sformatf("v%0d_err", i), bus1.rsp_err, vecs[i].err);
      chk($sformatf("v%0d_tag", i), bus1.rsp_tag, vecs[i].tag);
      chk($sformatf("v%0d_ctrl", i), a1_ctrl, vecs[i].ctrl);
      if (!vecs[i].err) chk($sformatf("v%0d_bonus", i), a1_bonus, vecs[i].cmp);
      tick();
      exp_done++;
      chk($sformatf("v%0d_done", i), done1, exp_done);
      chk($sformatf("v%0d_valid_clr", i), bus1.rsp_valid, 0);
    end

    // SUB 5-5 with the response stalled for 5 cycles.
    bus1.rsp_ready = 1'b0;
    send1(3'd3, 3'd0, 32'd5, 32'd5, 4'd6);
    lat = 0;
    do begin tick(); lat++; end while (!bus1.rsp_valid && lat < 20);
    chk("stall_valid", bus1.rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d_valid", k), bus1.rsp_valid, 1);
      chk($sformatf("stall%0d_result", k), bus1.rsp_result, 0);
      chk($sformatf("stall%0d_zero", k), bus1.rsp_zero, 1);
      chk($sformatf("stall%0d_tag", k), bus1.rsp_tag, 6);
      chk($sformatf("stall%0d_done", k), done1, exp_done);
    end
    bus1.rsp_ready = 1'b1;
    tick();
    exp_done++;
    chk("stall_done", done1, exp_done);
    chk("stall_valid_clr", bus1.rsp_valid, 0);

    // Fill: five accepted (four queued plus one in flight), sixth held off.
    bus1.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) send1(3'd2, 3'd0, t, 32'd16, 4'(t));
    bus1.req_valid = 1'b1;
    bus1.req_op = 3'd2;
    bus1.req_a = 32'd5;
    bus1.req_b = 32'd16;
    bus1.req_tag = 4'd5;
    chk("fill_full", bus1.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fill_hold%0d", k), bus1.req_ready, 0);
    end
    chk("fill_busy", busy1, 1);
    bus1.rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 100) begin
      acc = bus1.req_valid && bus1.req_ready;
      hs = bus1.rsp_valid && bus1.rsp_ready;
      if (hs) begin
        chk($sformatf("fill_tag%0d", got), bus1.rsp_tag, got);
        chk($sformatf("fill_res%0d", got), bus1.rsp_result, got + 16);
        got++;
      end
      tick();
      cyc++;
      if (acc) bus1.req_valid = 1'b0;
    end
    chk("fill_count", got, 6);
    exp_done += 6;
    chk("fill_done", done1, exp_done);

    // Illegal op sandwiched between two SLTs.
    bus1.rsp_ready = 1'b0;
    send1(3'd6, 3'd0, 32'hFFFF_FFFF, 32'd1, 4'd1);
    send1(3'd7, 3'd0, 32'd123, 32'd456, 4'd2);
    send1(3'd6, 3'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    exp_res[0] = 32'd1; exp_res[1] = 32'd0; exp_res[2] = 32'd1;
    exp_err[0] = 1'b0;  exp_err[1] = 1'b1;  exp_err[2] = 1'b0;
    bus1.rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 50) begin
      if (bus1.rsp_valid) begin
        chk($sformatf("ill%0d_err", got), bus1.rsp_err, exp_err[got]);
        chk($sformatf("ill%0d_result", got), bus1.rsp_result, exp_res[got]);
        chk($sformatf("ill%0d_tag", got), bus1.rsp_tag, got + 1);
        chk($sformatf("ill%0d_ctrl", got), a1_ctrl, 4'b0111);
        got++;
      end
      tick();
      cyc++;
    end
    chk("ill_count", got, 3);

    // Reset while in DRIVE with two requests still queued.
    bus1.rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) send1(3'd0, 3'd0, 32'h100 + t, 32'hFFFF_FFFF, 4'(t));
    bus1.rsp_ready = 1'b1;
    tick();
    chk("mid_src1", a1_src1, 32'h101);
    chk("mid_busy", busy1, 1);
    bus1.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", bus1.rsp_valid, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_ready", bus1.req_ready, 0);
    chk("mid_rst_alu_rst_n", a1_rst_n, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", bus1.req_ready, 1);
    bus1.rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus1.rsp_valid) stale++;
    end
    chk("mid_stale", stale, 0);
    chk("mid_done", done1, 0);
    chk("mid_idle_busy", busy1, 0);

    // SETTLE=3 instance: NOR hold window, then done_count wrap from a preload.
    force dut3.done_count_q = 16'hFFFE;
    tick();
    release dut3.done_count_q;
    tick();
    chk("d3_preload", done3, 16'hFFFE);
    bus3.rsp_ready = 1'b1;
    bus3.req_valid = 1'b1;
    bus3.req_op = 3'd4;
    bus3.req_cmp = 3'd3;
    bus3.req_a = 32'd0;
    bus3.req_b = 32'd0;
    bus3.req_tag = 4'd9;
    chk("d3_ready", bus3.req_ready, 1);
    tick();
    bus3.req_valid = 1'b0;
    lat = 0;
    held = 0;
    do begin
      tick();
      lat++;
      if (a3_ctrl == 4'b1100 && !bus3.rsp_valid) held++;
    end while (!bus3.rsp_valid && lat < 20);
    chk("d3_latency", lat, 4);
    chk("d3_held", held, 3);
    chk("d3_result", bus3.rsp_result, 32'hFFFF_FFFF);
    chk("d3_tag", bus3.rsp_tag, 9);
    chk("d3_bonus", a3_bonus, 3);
    tick();
    chk("d3_done_ffff", done3, 16'hFFFF);
    bus3.req_valid = 1'b1;
    bus3.req_op = 3'd2;
    bus3.req_a = 32'd1;
    bus3.req_b = 32'd1;
    bus3.req_tag = 4'd10;
    tick();
    bus3.req_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!bus3.rsp_valid && lat < 20);
    chk("d3_add_result", bus3.rsp_result, 32'd2);
    tick();
    chk("d3_done_wrap", done3, 16'h0000);
    chk("d3_alu_rst_n", a3_rst_n, 1);
    chk("d3_busy", busy3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
